seg_digit_receiver: RTL
=======================

SEG_DIGIT_RECEIVER -- requirements
Module: seg_digit_receiver

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have port: seg_in  input  7  digit as segment pattern, bit order {g,f,e,d,c,b,a}, 1 = segment lit.
REQ-004 SHALL have port: seg_valid  input  1  seg_in holds a digit.
REQ-005 SHALL have port: seg_ready  output  1  block accepts a digit this cycle.
REQ-006 SHALL have port: abort  input  1  synchronous discard of any partial or pending operand.
REQ-007 SHALL have port: bin_out  output  5  converted binary operand, 0..31.
REQ-008 SHALL have port: bin_valid  output  1  bin_out holds a result.
REQ-009 SHALL have port: bin_ready  input  1  consumer takes the result.
REQ-010 SHALL have port: err  output  1  one-cycle error pulse.
REQ-011 SHALL have port: err_code  output  2  01 = illegal pattern, 10 = value > 31; held until next error.

Function
REQ-012 SHALL decode patterns 0111111=0, 0000110=1, 1011011=2, 1001111=3, 1100110=4, 1101101=5, 1111101=6, 0000111=7, 1111111=8, 1101111=9; every other pattern is illegal.
REQ-013 SHALL implement FSM states: TENS, ONES, CONVERT, HOLD.
REQ-014 SHALL drive seg_ready = 1 in TENS and ONES only; handshake = seg_valid & seg_ready at a rising edge.
REQ-015 TENS: legal digit handshake -> store as tens, go to ONES.
REQ-016 ONES: legal digit handshake -> store as ones, go to CONVERT.
REQ-017 Illegal pattern handshake in TENS or ONES -> err pulse next cycle, err_code = 01, discard tens, go to TENS.
REQ-018 CONVERT: compute tens*8 + tens*2 + ones at 7-bit width, with no multiplier.
REQ-019 CONVERT, result <= 31: load bin_out, go to HOLD.
REQ-020 CONVERT, result > 31: err pulse, err_code = 10, bin_out unchanged, go to TENS.
REQ-021 bin_valid = 1 exactly while in HOLD; first high one cycle after CONVERT (two edges after the ones handshake).
REQ-022 HOLD: bin_out stable; bin_ready = 1 -> go to TENS; otherwise stay in HOLD indefinitely.
REQ-023 No digit is accepted in CONVERT or HOLD; seg_valid there is ignored and not buffered.
REQ-024 abort = 1 -> go to TENS at next edge from any state, drop stored digits and any held result, no err pulse.
REQ-025 abort takes priority over a same-cycle digit handshake or bin_ready.
REQ-026 err SHALL be high for exactly one cycle per error event; back-to-back errors give back-to-back pulses.
REQ-027 Leading zero is required: single-digit values are entered as tens = 0.

Reset
REQ-028 rst = 1 SHALL immediately force: state TENS, bin_out = 0, bin_valid = 0, err = 0, err_code = 00, stored digits = 0, seg_ready = 1.
REQ-029 Reset asserted mid-operation SHALL discard all partial input without an error pulse.

Structure
REQ-030 A shared package SHALL hold the ten segment-pattern constants, the FSM state encoding and the err_code values; the existing seven-segment encoder uses the same constants.
REQ-031 SHALL contain one sub-module, seg7_to_bcd: combinational, 7-bit pattern in, 4-bit BCD plus illegal flag out.

Verification
REQ-032 Digits 2 then 5 (1011011, 1101101) -> bin_out = 25 (11001), bin_valid two edges after the second handshake, held until bin_ready.
REQ-033 Digits 3 then 2 -> value 32 -> err pulse, err_code = 10, bin_valid stays 0, FSM back in TENS.
REQ-034 Tens pattern 1111100 -> err pulse, err_code = 01; then 0, 7 -> bin_out = 7.
REQ-035 Result 0,9 held with bin_ready = 0 for 10 cycles, seg_valid = 1 throughout -> bin_out = 9 stable, seg_ready = 0; bin_ready pulse -> TENS.
REQ-036 abort together with the ones handshake, and rst asserted in ONES -> return to TENS, no err, no bin_valid; then 3, 1 -> bin_out = 31.

Source files
------------

// File: rtl/seg_digit_receiver_pkg.sv
// Shared constants for the seven-segment digit path: segment patterns,
// receiver FSM encoding and error codes.
package seg_digit_receiver_pkg;

  // Segment bit order is {g,f,e,d,c,b,a}, 1 = lit.
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;

  typedef logic [1:0] state_t;

  localparam state_t ST_TENS    = 2'd0;
  localparam state_t ST_ONES    = 2'd1;
  localparam state_t ST_CONVERT = 2'd2;
  localparam state_t ST_HOLD    = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;

  // tens*10 + ones as shift-and-add; 99 is the largest value and fits 7 bits.
  function automatic logic [6:0] bcd_pair_value(input logic [3:0] tens,
                                                input logic [3:0] ones);
    return {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, ones};
  endfunction

endpackage

// File: rtl/seg_digit_receiver_seg7.sv
// Combinational seven-segment pattern to BCD decoder with an illegal-pattern flag.
module seg7_to_bcd
  import seg_digit_receiver_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       illegal_o
);

  always_comb begin
    bcd_o     = 4'd0;
    illegal_o = 1'b0;
    case (seg_i)
      SEG_0:   bcd_o = 4'd0;
      SEG_1:   bcd_o = 4'd1;
      SEG_2:   bcd_o = 4'd2;
      SEG_3:   bcd_o = 4'd3;
      SEG_4:   bcd_o = 4'd4;
      SEG_5:   bcd_o = 4'd5;
      SEG_6:   bcd_o = 4'd6;
      SEG_7:   bcd_o = 4'd7;
      SEG_8:   bcd_o = 4'd8;
      SEG_9:   bcd_o = 4'd9;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_digit_receiver.sv
// Receives two seven-segment digits (tens, ones) and emits their binary value
// when it is 0..31, otherwise flags an error.
//
// state   | meaning
// TENS    | waiting for the tens digit
// ONES    | tens stored, waiting for the ones digit
// CONVERT | both digits stored, range-checking the combined value
// HOLD    | result presented on bin_out until bin_ready
module seg_digit_receiver
  import seg_digit_receiver_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       seg_valid,
  output logic       seg_ready,
  input  logic       abort,
  output logic [4:0] bin_out,
  output logic       bin_valid,
  input  logic       bin_ready,
  output logic       err,
  output logic [1:0] err_code
);

  state_t     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [4:0] bin_q, bin_d;
  logic       err_q, err_d;
  logic [1:0] err_code_q, err_code_d;

  logic [3:0] digit_bcd;
  logic       digit_illegal;
  logic       handshake;
  logic [6:0] value;

  seg7_to_bcd u_seg7_to_bcd (
    .seg_i     (seg_in),
    .bcd_o     (digit_bcd),
    .illegal_o (digit_illegal)
  );

  assign seg_ready = (state_q == ST_TENS) || (state_q == ST_ONES);
  assign handshake = seg_valid && seg_ready;
  assign value     = bcd_pair_value(tens_q, ones_q);

  always_comb begin
    state_d    = state_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    bin_d      = bin_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    // abort wins over any handshake, conversion outcome or bin_ready
    if (abort) begin
      state_d = ST_TENS;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      bin_d   = 5'd0;
    end else begin
      case (state_q)
        ST_TENS: begin
          if (handshake) begin
            if (digit_illegal) begin
              err_d      = 1'b1;
              err_code_d = ERR_ILLEGAL;
              tens_d     = 4'd0;
            end else begin
              tens_d  = digit_bcd;
              state_d = ST_ONES;
            end
          end
        end
        ST_ONES: begin
          if (handshake) begin
            if (digit_illegal) begin
              err_d      = 1'b1;
              err_code_d = ERR_ILLEGAL;
              tens_d     = 4'd0;
              state_d    = ST_TENS;
            end else begin
              ones_d  = digit_bcd;
              state_d = ST_CONVERT;
            end
          end
        end
        ST_CONVERT: begin
          tens_d = 4'd0;
          ones_d = 4'd0;
          if (value <= 7'd31) begin
            bin_d   = value[4:0];
            state_d = ST_HOLD;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_RANGE;
            state_d    = ST_TENS;
          end
        end
        ST_HOLD: begin
          if (bin_ready) state_d = ST_TENS;
        end
        default: state_d = ST_TENS;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_TENS;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      bin_q      <= 5'd0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      bin_q      <= bin_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bin_out   = bin_q;
  assign bin_valid = (state_q == ST_HOLD);
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule
